// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with PC register and IF/ID pipeline outputs.
// Optional skid buffer selected by the FETCH_SKID_EN macro: when defined, a memory
// response arriving during a stall is captured and replayed once the stall clears.
// When undefined, the request is withheld while stalled and the fetch is reissued.
module fetch_stage (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRdy,
  input  logic [31:0] ImemData,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out,
  output logic [31:0] Instr_out,
  output logic        Valid_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef FETCH_SKID_EN
    HOLD = 2'd2,
`endif
    REQ  = 2'd1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] redirect;

`ifdef FETCH_SKID_EN
  logic [31:0] skid_data;
`endif

  // Word-aligned redirect address and wrapping sequential PC.
  assign redirect = BranchTarget & 32'hFFFF_FFFC;
  assign pc_next  = pc + 32'd4;
  assign ImemAddr = pc;

`ifdef FETCH_SKID_EN
  // The skid buffer absorbs a stalled response, so the request stays up in REQ.
  assign ImemReq = (state == REQ);
`else
  // Without a skid buffer a stalled response would be lost, so do not ask for one.
  assign ImemReq = (state == REQ) && !Stall;
`endif

  // PC, FSM and IF/ID register update: reset, then flush, then stall, then response.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      pc        <= 32'd0;
      PC_out    <= 32'd0;
      PC4_out   <= 32'd0;
      Instr_out <= 32'd0;
      Valid_out <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_data <= 32'd0;
`endif
    end else if (Flush) begin
      state     <= REQ;
      pc        <= redirect;
      Instr_out <= 32'd0;
      Valid_out <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_data <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (Stall) begin
`ifdef FETCH_SKID_EN
            if (ImemRdy) begin
              skid_data <= ImemData;
              state     <= HOLD;
            end
`endif
          end else if (ImemRdy) begin
            PC_out    <= pc;
            PC4_out   <= pc_next;
            Instr_out <= ImemData;
            Valid_out <= 1'b1;
            pc        <= pc_next;
          end else begin
            Instr_out <= 32'd0;
            Valid_out <= 1'b0;
          end
        end
`ifdef FETCH_SKID_EN
        HOLD: begin
          if (!Stall) begin
            PC_out    <= pc;
            PC4_out   <= pc_next;
            Instr_out <= skid_data;
            Valid_out <= 1'b1;
            pc        <= pc_next;
            state     <= REQ;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Clk  input  1  rising-edge clock; all state SHALL update only on posedge Clk.
REQ-002 Reset_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-003 Stall  input  1  hazard-unit hold; freezes the PC and the IF/ID outputs.
REQ-004 Flush  input  1  taken branch resolved in ID; redirects the PC and bubbles IF/ID.
REQ-005 BranchTarget  input  32  redirect address; bits [1:0] SHALL be treated as 0.
REQ-006 ImemReq  output  1  instruction-memory read request.
REQ-007 ImemAddr  output  32  fetch address, equal to the PC register at all times.
REQ-008 ImemRdy  input  1  memory has returned ImemData for ImemAddr in this cycle.
REQ-009 ImemData  input  32  instruction word returned by memory.
REQ-010 PC_out  output  32  IF/ID: address of the held instruction.
REQ-011 PC4_out  output  32  IF/ID: PC_out+4, modulo 2^32.
REQ-012 Instr_out  output  32  IF/ID: held instruction word; 32'd0 when it is a bubble.
REQ-013 Valid_out  output  1  IF/ID: 1 when Instr_out is a real instruction.

Function
REQ-014 The FSM SHALL have these states: IDLE, REQ, and HOLD (HOLD exists only with FETCH_SKID_EN).
REQ-015 IDLE SHALL go to REQ unconditionally on the next cycle, with ImemReq=0 while in IDLE.
REQ-016 In REQ, ImemReq SHALL be 1, gated by !Stall when FETCH_SKID_EN is undefined.
REQ-017 Priority each cycle SHALL be: Flush > Stall > ImemRdy.
REQ-018 On Flush in any state: PC<={BranchTarget[31:2],2'b00}, Valid_out<=0, Instr_out<=0, any skid contents discarded, next state REQ.
REQ-019 Flush SHALL also discard an ImemRdy response that arrives in the same cycle.
REQ-020 In REQ with ImemRdy=1 and Stall=0: PC_out<=PC, PC4_out<=PC+4, Instr_out<=ImemData, Valid_out<=1, PC<=PC+4, remain in REQ.
REQ-021 In REQ with ImemRdy=0 and Stall=0: Valid_out<=0 and Instr_out<=0 (bubble); the PC SHALL hold.
REQ-022 With Stall=1 and Flush=0, PC_out, PC4_out, Instr_out and Valid_out SHALL hold their values.
REQ-023 The PC increment SHALL wrap, so that 32'hFFFFFFFC+4 gives 32'h00000000, with PC4_out wrapping the same way.
REQ-024 Fetch latency SHALL be one cycle: data accepted at edge N SHALL be visible on the IF/ID outputs after edge N.

Reset
REQ-025 When Reset_n=0 at posedge Clk: PC=0, state=IDLE, ImemReq=0, PC_out=0, PC4_out=0, Instr_out=0, Valid_out=0, and the skid buffer is empty.
REQ-026 Reset SHALL override Flush and Stall, and SHALL abort any outstanding fetch; a response in the reset cycle SHALL be dropped.

Configuration
REQ-027 Macro FETCH_SKID_EN defined, REQ with ImemRdy=1, Stall=1, Flush=0: capture ImemData into the skid buffer and go to HOLD.
REQ-028 In HOLD: ImemReq=0; on Stall=0, load IF/ID from the skid buffer per REQ-020, advance the PC, and return to REQ.
REQ-029 In HOLD with Stall=1, the block SHALL remain in HOLD.
REQ-030 FETCH_SKID_EN undefined: there SHALL be no HOLD state and no skid register, and ImemRdy SHALL be ignored while Stall=1 (ImemReq is already 0).

Verification
REQ-031 The bench SHALL drive Reset_n=0 for 2 cycles, then release with ImemRdy=1 and ImemData=32'hE3A01005. Required response: the first IF/ID load has PC_out=0, PC4_out=4, Valid_out=1, and the next ImemAddr=4.
REQ-032 The bench SHALL hold ImemRdy=1 and then pulse Flush with BranchTarget=32'h00000103. Required response: the next ImemAddr=32'h00000100, Valid_out=0, Instr_out=0, and the same-cycle data is dropped.
REQ-033 The bench SHALL stall for 3 cycles at PC=8 with ImemRdy=1. With FETCH_SKID_EN, the IF/ID outputs hold, then Instr_out=data@8 one cycle after Stall drops. Without it, ImemReq=0 during the stall and the fetch of 8 is reissued afterwards.
REQ-034 The bench SHALL preload PC=32'hFFFFFFFC via Flush and then return ImemRdy=1. Required response: PC4_out=0 and the next ImemAddr=0.
REQ-035 The bench SHALL assert Stall and Flush in the same cycle. Required response: the flush behaviour of REQ-018 wins.
REQ-036 The bench SHALL assert Reset_n=0 while in HOLD, or while ImemRdy=1. Required response: every output takes its REQ-025 value after that edge.
